// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - two-stage pipelined carry-lookahead adder/subtractor with valid/ready stream
`timescale 1ns/1ps
module pipelined_cla_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             pg,
    output logic             gg
);
    localparam int GROUPS = WIDTH / 4;
    localparam int LEVELS = $clog2(GROUPS);

    // Carries into bits 0..3 plus the group carry-out, flat two-level form.
    function automatic logic [4:0] cla4(input logic [3:0] p, input logic [3:0] g, input logic c);
        logic [4:0] r;
        r[0] = c;
        r[1] = g[0] | (p[0] & c);
        r[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
        r[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
        r[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c);
        return r;
    endfunction

    logic              v1, v2, en1, en2;
    logic [WIDTH-1:0]  p_d, g_d, p_q, g_q;
    logic [GROUPS-1:0] grp_p_d, grp_g_d, grp_p_q, grp_g_q;
    logic              c0_d, c0_q;

    assign en2       = !v2 | out_ready;
    assign en1       = !v1 | en2;
    assign in_ready  = en1;
    assign out_valid = v2;

    always_comb begin
        logic [WIDTH-1:0] bx;
        logic [4:0]       t;
        bx      = sub ? ~b : b;
        c0_d    = sub ? ~cin : cin;
        p_d     = a ^ bx;
        g_d     = a & bx;
        grp_p_d = '0;
        grp_g_d = '0;
        t       = '0;
        for (int k = 0; k < GROUPS; k++) begin
            t          = cla4(p_d[4*k +: 4], g_d[4*k +: 4], 1'b0);
            grp_g_d[k] = t[4];
            grp_p_d[k] = &p_d[4*k +: 4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            p_q     <= '0;
            g_q     <= '0;
            grp_p_q <= '0;
            grp_g_q <= '0;
            c0_q    <= 1'b0;
        end else if (en1) begin
            v1 <= in_valid;
            if (in_valid) begin
                p_q     <= p_d;
                g_q     <= g_d;
                grp_p_q <= grp_p_d;
                grp_g_q <= grp_g_d;
                c0_q    <= c0_d;
            end
        end
    end

    logic [GROUPS-1:0] pre_p, pre_g;
    logic [GROUPS:0]   grp_c;
    logic [WIDTH-1:0]  carry, sum_d;
    logic              cout_d, ovf_d;

    // Parallel-prefix over group (G,P) pairs: log2(GROUPS) levels, no ripple between groups.
    always_comb begin
        logic [4:0] cv;
        pre_p = grp_p_q;
        pre_g = grp_g_q;
        for (int l = 0; l < LEVELS; l++) begin
            for (int k = GROUPS - 1; k >= (1 << l); k--) begin
                pre_g[k] = pre_g[k] | (pre_p[k] & pre_g[k - (1 << l)]);
                pre_p[k] = pre_p[k] & pre_p[k - (1 << l)];
            end
        end
        grp_c    = '0;
        grp_c[0] = c0_q;
        for (int k = 0; k < GROUPS; k++)
            grp_c[k+1] = pre_g[k] | (pre_p[k] & c0_q);
        carry = '0;
        cv    = '0;
        for (int k = 0; k < GROUPS; k++) begin
            cv               = cla4(p_q[4*k +: 4], g_q[4*k +: 4], grp_c[k]);
            carry[4*k +: 4]  = cv[3:0];
        end
        sum_d  = p_q ^ carry;
        cout_d = grp_c[GROUPS];
        ovf_d  = carry[WIDTH-1] ^ grp_c[GROUPS];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2   <= 1'b0;
            s    <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
            pg   <= 1'b0;
            gg   <= 1'b0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                s    <= sum_d;
                cout <= cout_d;
                ovf  <= ovf_d;
                pg   <= pre_p[GROUPS-1];
                gg   <= pre_g[GROUPS-1];
            end
        end
    end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - self-checking bench for pipelined_cla_adder at widths 16, 4 and 32
`timescale 1ns/1ps
module tb_pipelined_cla_adder;
    typedef struct {
        longint s;
        bit     cout;
        bit     ovf;
        bit     pg;
        bit     gg;
        bit     c0;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic        in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0, sub = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        in_ready, out_valid, cout, ovf, pg, gg;
    logic [15:0] s;

    logic        w4_in_valid = 1'b0, w4_out_ready = 1'b1, w4_cin = 1'b0, w4_sub = 1'b0;
    logic [3:0]  w4_a = '0, w4_b = '0;
    logic        w4_in_ready, w4_out_valid, w4_cout, w4_ovf, w4_pg, w4_gg;
    logic [3:0]  w4_s;

    logic        w32_in_valid = 1'b0, w32_out_ready = 1'b1, w32_cin = 1'b0, w32_sub = 1'b0;
    logic [31:0] w32_a = '0, w32_b = '0;
    logic        w32_in_ready, w32_out_valid, w32_cout, w32_ovf, w32_pg, w32_gg;
    logic [31:0] w32_s;

    pipelined_cla_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf), .pg(pg), .gg(gg)
    );
    pipelined_cla_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(w4_in_valid), .in_ready(w4_in_ready),
        .a(w4_a), .b(w4_b), .cin(w4_cin), .sub(w4_sub), .out_valid(w4_out_valid), .out_ready(w4_out_ready),
        .s(w4_s), .cout(w4_cout), .ovf(w4_ovf), .pg(w4_pg), .gg(w4_gg)
    );
    pipelined_cla_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(w32_in_valid), .in_ready(w32_in_ready),
        .a(w32_a), .b(w32_b), .cin(w32_cin), .sub(w32_sub), .out_valid(w32_out_valid), .out_ready(w32_out_ready),
        .s(w32_s), .cout(w32_cout), .ovf(w32_ovf), .pg(w32_pg), .gg(w32_gg)
    );

    // Reference: plain integer arithmetic on unsigned/signed interpretations.
    function automatic res_t model(input int w, input longint av, input longint bv, input bit ci, input bit sb);
        res_t   r;
        longint m, half, sa, sbv, t, ts;
        m    = longint'(1) << w;
        half = m / 2;
        sa   = (av >= half) ? av - m : av;
        sbv  = (bv >= half) ? bv - m : bv;
        r.c0 = sb ? !ci : ci;
        if (!sb) begin
            t      = av + bv + longint'(ci);
            r.s    = t % m;
            r.cout = t >= m;
            ts     = sa + sbv + longint'(ci);
            r.pg   = (av ^ bv) == m - 1;
            r.gg   = (av + bv) >= m;
        end else begin
            t      = av - bv - longint'(ci);
            r.s    = (t < 0) ? t + m : t;
            r.cout = t >= 0;
            ts     = sa - sbv - longint'(ci);
            r.pg   = av == bv;
            r.gg   = av > bv;
        end
        r.ovf = (ts >= half) || (ts < -half);
        return r;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total++;
        if ({out_valid, s, cout, ovf, pg, gg} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want all zero", {out_valid, s, cout, ovf, pg, gg});
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_corners();
        logic [15:0] va [6] = '{16'h0005, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h0003, 16'h8000};
        logic [15:0] vb [6] = '{16'h0006, 16'h0001, 16'h0000, 16'h0001, 16'h0005, 16'h0001};
        bit          vc [6] = '{0, 0, 1, 0, 0, 0};
        bit          vs [6] = '{0, 0, 0, 0, 1, 1};
        logic [15:0] es [6] = '{16'h000B, 16'h0000, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF};
        bit          ec [6] = '{0, 1, 1, 0, 0, 1};
        bit          eo [6] = '{0, 0, 0, 1, 0, 1};
        bit          ep [6] = '{0, 0, 1, 0, 0, 0};
        bit          eg [6] = '{0, 1, 0, 0, 0, 1};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a = va[i]; b = vb[i]; cin = vc[i]; sub = vs[i]; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL corner%0d_early: got out_valid=%b want 0", i, out_valid);
            end
            @(negedge clk);
            total++;
            if ({out_valid, s, cout, ovf, pg, gg} !== {1'b1, es[i], ec[i], eo[i], ep[i], eg[i]}) begin
                bad++;
                $display("FAIL corner%0d: got v=%b s=%h c=%b o=%b p=%b g=%b want v=1 s=%h c=%b o=%b p=%b g=%b",
                         i, out_valid, s, cout, ovf, pg, gg, es[i], ec[i], eo[i], ep[i], eg[i]);
            end
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL corner%0d_single: got out_valid=%b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] xa [3], xb [3];
        bit          xc [3], xs [3];
        res_t        e  [3];
        for (int i = 0; i < 3; i++) begin
            xa[i] = 16'($urandom()); xb[i] = 16'($urandom());
            xc[i] = 1'($urandom()); xs[i] = 1'($urandom());
            e[i]  = model(16, longint'(xa[i]), longint'(xb[i]), xc[i], xs[i]);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = xa[i]; b = xb[i]; cin = xc[i]; sub = xs[i]; in_valid = 1'b1;
            #1;
            total++;
            if (in_ready !== (i < 2)) begin
                bad++;
                $display("FAIL bp_in_ready%0d: got %b want %b", i, in_ready, i < 2);
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            total++;
            if (in_ready !== 1'b0 || {out_valid, s, cout, ovf, pg, gg} !==
                {1'b1, 16'(e[0].s), e[0].cout, e[0].ovf, e[0].pg, e[0].gg}) begin
                bad++;
                $display("FAIL bp_frozen%0d: got rdy=%b v=%b s=%h want rdy=0 v=1 s=%h", i, in_ready, out_valid, s, 16'(e[0].s));
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release_ready: got %b want 1", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                #1;
            end
            total++;
            if ({out_valid, s, cout, ovf, pg, gg} !== {1'b1, 16'(e[i].s), e[i].cout, e[i].ovf, e[i].pg, e[i].gg}) begin
                bad++;
                $display("FAIL bp_order%0d: got v=%b s=%h c=%b want v=1 s=%h c=%b", i, out_valid, s, cout, 16'(e[i].s), e[i].cout);
            end
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        res_t q[$];
        res_t e;
        int   sent = 0, cyc = 0;
        while ((sent < 100 || q.size() > 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
            a = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom());
            b = ($urandom_range(0, 7) == 0) ? ~a : 16'($urandom());
            cin = 1'($urandom()); sub = 1'($urandom());
            #1;
            if (out_valid && out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra: got unexpected beat s=%h want none", s);
                end else begin
                    e = q.pop_front();
                    if ({s, cout, ovf, pg, gg} !== {16'(e.s), e.cout, e.ovf, e.pg, e.gg}) begin
                        bad++;
                        $display("FAIL b2b_result: got s=%h c=%b o=%b p=%b g=%b want s=%h c=%b o=%b p=%b g=%b",
                                 s, cout, ovf, pg, gg, 16'(e.s), e.cout, e.ovf, e.pg, e.gg);
                    end
                    total++;
                    if (cout !== (gg | (pg & e.c0))) begin
                        bad++;
                        $display("FAIL b2b_invariant: got cout=%b want %b", cout, gg | (pg & e.c0));
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(16, longint'(a), longint'(b), cin, sub));
                sent++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (sent != 100 || q.size() != 0) begin
            bad++;
            $display("FAIL b2b_complete: got sent=%0d pending=%0d want 100 0", sent, q.size());
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            a = 16'($urandom()); b = 16'($urandom()); cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_inflight: got out_valid=%b want 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, s, cout, ovf, pg, gg} !== 21'd0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_clear: got %b rdy=%b want zero rdy=1", {out_valid, s, cout, ovf, pg, gg}, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++;
                $display("FAIL rst_mid_stale%0d: got out_valid=%b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_width4();
        res_t q[$];
        res_t e;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            w4_in_valid = (cyc < 70) && 1'($urandom());
            w4_a = 4'($urandom()); w4_b = 4'($urandom());
            w4_cin = 1'($urandom()); w4_sub = 1'($urandom());
            #1;
            if (w4_out_valid) begin
                total++;
                e = (q.size() > 0) ? q.pop_front() : '{default: 0};
                if ({w4_s, w4_cout, w4_ovf, w4_pg, w4_gg} !== {4'(e.s), e.cout, e.ovf, e.pg, e.gg}
                    || w4_cout !== (w4_gg | (w4_pg & e.c0))) begin
                    bad++;
                    $display("FAIL w4_result: got s=%h c=%b o=%b p=%b g=%b want s=%h c=%b o=%b p=%b g=%b",
                             w4_s, w4_cout, w4_ovf, w4_pg, w4_gg, 4'(e.s), e.cout, e.ovf, e.pg, e.gg);
                end
            end
            if (w4_in_valid && w4_in_ready)
                q.push_back(model(4, longint'(w4_a), longint'(w4_b), w4_cin, w4_sub));
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL w4_drain: got pending=%0d want 0", q.size());
        end
    endtask

    task automatic test_width32();
        res_t q[$];
        res_t e;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            w32_in_valid = (cyc < 70) && 1'($urandom());
            w32_a = $urandom();
            w32_b = ($urandom_range(0, 3) == 0) ? ~w32_a : $urandom();
            w32_cin = 1'($urandom()); w32_sub = 1'($urandom());
            #1;
            if (w32_out_valid) begin
                total++;
                e = (q.size() > 0) ? q.pop_front() : '{default: 0};
                if ({w32_s, w32_cout, w32_ovf, w32_pg, w32_gg} !== {32'(e.s), e.cout, e.ovf, e.pg, e.gg}
                    || w32_cout !== (w32_gg | (w32_pg & e.c0))) begin
                    bad++;
                    $display("FAIL w32_result: got s=%h c=%b o=%b p=%b g=%b want s=%h c=%b o=%b p=%b g=%b",
                             w32_s, w32_cout, w32_ovf, w32_pg, w32_gg, 32'(e.s), e.cout, e.ovf, e.pg, e.gg);
                end
            end
            if (w32_in_valid && w32_in_ready)
                q.push_back(model(32, longint'(w32_a), longint'(w32_b), w32_cin, w32_sub));
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL w32_drain: got pending=%0d want 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_corners();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_width4();
        test_width32();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
